// File: rtl/char_link_pkg.sv
// Framing shared by both ends of the player-state UART link: sync byte, byte order, state record.
// CHAR_TX_CHECKSUM_EN appends an XOR checksum byte; transmitter and receiver must agree on it.
package char_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef CHAR_TX_CHECKSUM_EN
  localparam int PKT_BYTES = 6;
`else
  localparam int PKT_BYTES = 5;
`endif

  localparam int IDX_W = 3;
  typedef logic [IDX_W-1:0] pkt_idx_t;

  localparam pkt_idx_t IDX_SYNC   = 3'd0;
  localparam pkt_idx_t IDX_X_LO   = 3'd1;
  localparam pkt_idx_t IDX_XY_MIX = 3'd2;
  localparam pkt_idx_t IDX_Y_HI   = 3'd3;
  localparam pkt_idx_t IDX_LEVEL  = 3'd4;
  localparam pkt_idx_t IDX_CSUM   = 3'd5;
  localparam pkt_idx_t IDX_LAST   = pkt_idx_t'(PKT_BYTES - 1);

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  level;
  } char_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_LOAD,
    T_SEND,
    T_WAIT,
    T_DONE
  } tx_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

  function automatic logic [7:0] pkt_byte(input char_state_t s, input pkt_idx_t idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      IDX_SYNC:   b = SYNC_BYTE;
      IDX_X_LO:   b = s.x[7:0];
      IDX_XY_MIX: b = {s.y[3:0], s.x[11:8]};
      IDX_Y_HI:   b = s.y[11:4];
      IDX_LEVEL:  b = {6'b0, s.level};
`ifdef CHAR_TX_CHECKSUM_EN
      IDX_CSUM:   b = s.x[7:0] ^ {s.y[3:0], s.x[11:8]} ^ s.y[11:4] ^ {6'b0, s.level};
`endif
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high; accepts a byte only in S_IDLE (byte_valid & byte_ready).
// The S_IDLE handshake cycle supplies the last stop-bit cycle, so chained bytes abut with no gap.
module uart_tx_byte
  import char_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx,
  output logic       byte_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT - 2);

  ser_state_e    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    byte_ready = (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          shift_d = byte_data;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        // Stop ends one cycle early here; the following S_IDLE cycle is its final (high) cycle.
        if (baud_q == STOP_LAST) begin
          baud_d    = '0;
          byte_done = 1'b1;
          state_d   = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/char_state_uart_tx.sv
// Player-state UART transmitter: snapshots x/y/level on an accepted send_req, start bit 2 cycles later.
// Sends 5 bytes (6 with CHAR_TX_CHECKSUM_EN); requests while busy are dropped, not queued.
module char_state_uart_tx
  import char_link_pkg::*;
#(
  parameter int CLK_HZ       = 65_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  input  logic [1:0]  level,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  tx_state_e   state_q, state_d;
  char_state_t snap_q, snap_d;
  pkt_idx_t    idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        byte_valid;
  logic        byte_ready;
  logic        byte_done;
  logic [7:0]  byte_data;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    byte_valid = 1'b0;
    byte_data  = pkt_byte(snap_q, idx_q);

    case (state_q)
      T_IDLE: begin
        if (send_req) begin
          snap_d.x     = x_value;
          snap_d.y     = y_value;
          snap_d.level = level;
          idx_d        = IDX_SYNC;
          state_d      = T_LOAD;
        end
      end
      // The serializer is always idle in LOAD, so byte 0 is offered at once to hit the n+2 start bit.
      T_LOAD, T_SEND: begin
        byte_valid = 1'b1;
        state_d    = byte_ready ? T_WAIT : T_SEND;
      end
      T_WAIT: begin
        if (byte_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = T_DONE;
          end else begin
            idx_d   = idx_q + pkt_idx_t'(1);
            state_d = T_SEND;
          end
        end
      end
      T_DONE:  state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase

    // DONE coincides with the final stop cycle on the line; done/busy flags land one cycle later.
    busy_d = (state_d != T_IDLE);
    done_d = (state_q == T_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_IDLE;
      snap_q  <= '0;
      idx_q   <= IDX_SYNC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (tx),
    .byte_done (byte_done)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_char_state_uart_tx.sv
// Scoreboard bench for char_state_uart_tx: stimulus queues expected bytes/done cycles, monitors decode tx.
`timescale 1ns/1ps
module tb_char_state_uart_tx;

  localparam int CPB     = 10;
  localparam int BIT_CYC = 10 * CPB;
`ifdef CHAR_TX_CHECKSUM_EN
  localparam int PKT = 6;
`else
  localparam int PKT = 5;
`endif
  localparam int PKT_CYC  = PKT * BIT_CYC;
  localparam int DONE_OFS = 2 + PKT_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic [11:0] x_value = 12'h000;
  logic [11:0] y_value = 12'h000;
  logic [1:0]  level = 2'd0;
  logic        tx, busy, done;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] b;
    int         at;
  } exp_byte_t;

  exp_byte_t byte_q[$];
  int        done_q[$];

  // Hand-computed packets, last column is the XOR checksum.
  // 0: x=123 y=2AB l=2 | 1: x=456 y=789 l=1 | 2: x=ABC y=DEF l=3
  // 3: x=000 y=FFF l=0 | 4: x=5A3 y=0C6 l=2 | 5: x=321 y=654 l=1
  logic [7:0] vec [0:5][0:5] = '{
    '{8'hA5, 8'h23, 8'hB1, 8'h2A, 8'h02, 8'hBA},
    '{8'hA5, 8'h56, 8'h94, 8'h78, 8'h01, 8'hBB},
    '{8'hA5, 8'hBC, 8'hFA, 8'hDE, 8'h03, 8'h9B},
    '{8'hA5, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'h0F},
    '{8'hA5, 8'hA3, 8'h65, 8'h0C, 8'h02, 8'hC8},
    '{8'hA5, 8'h21, 8'h43, 8'h65, 8'h01, 8'h06}
  };

  char_state_uart_tx #(
    .CLK_HZ(1000),
    .BAUD  (100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .send_req(send_req),
    .x_value (x_value),
    .y_value (y_value),
    .level   (level),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_pkt(input int row, input int req);
    exp_byte_t e;
    for (int k = 0; k < PKT; k++) begin
      e.b  = vec[row][k];
      e.at = req + 2 + k * BIT_CYC;
      byte_q.push_back(e);
    end
    done_q.push_back(req + DONE_OFS);
  endtask

  task automatic send_pkt(input int row, input logic [11:0] x, input logic [11:0] y,
                          input logic [1:0] l, output int req);
    step();
    x_value  = x;
    y_value  = y;
    level    = l;
    send_req = 1'b1;
    req      = cyc;
    push_pkt(row, req);
    step();
    send_req = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
  endtask

  initial begin : byte_mon
    logic [BIT_CYC-1:0] s;
    int         start;
    bit         aborted;
    bit         framed;
    logic [7:0] got;
    exp_byte_t  e;
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0) begin
        start   = cyc;
        aborted = 1'b0;
        for (int i = 0; i < BIT_CYC && !aborted; i++) begin
          if (i != 0) @(negedge clk);
          if (rst) aborted = 1'b1;
          s[i] = tx;
        end
        if (!aborted) begin
          framed = (s[0] == 1'b0) && (s[BIT_CYC-CPB] == 1'b1);
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
              if (s[b*CPB+k] != s[b*CPB]) framed = 1'b0;
          for (int j = 0; j < 8; j++) got[j] = s[(j+1)*CPB];
          chk("byte_expected", byte_q.size() > 0, 1);
          if (byte_q.size() > 0) begin
            e = byte_q.pop_front();
            chk("byte_value", got, e.b);
            chk("byte_start_cycle", start, e.at);
            chk("byte_framing", framed, 1);
          end
        end
      end
    end
  end

  initial begin : done_mon
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
        chk("done_busy_before", prev_busy, 1);
        chk("done_busy_low", busy, 0);
        chk("done_tx_idle", tx, 1);
      end
      prev_busy = busy;
    end
  end

  initial begin : stim
    int req;
    bit idle_ok;

    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    step();
    rst = 1'b0;

    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_50", idle_ok, 1);

    // Basic packet
    send_pkt(0, 12'h123, 12'h2AB, 2'd2, req);
    wait_until(req + DONE_OFS + 10);

    // Inputs and a request change while B1 is on the line
    send_pkt(0, 12'h123, 12'h2AB, 2'd2, req);
    wait_until(req + 2 + BIT_CYC + 50);
    x_value  = 12'hFFF;
    send_req = 1'b1;
    step();
    send_req = 1'b0;
    wait_until(req + DONE_OFS + 10);

    // Held request: three packets, new inputs picked up at each acceptance
    step();
    x_value  = 12'h456;
    y_value  = 12'h789;
    level    = 2'd1;
    send_req = 1'b1;
    req      = cyc;
    push_pkt(1, req);
    push_pkt(2, req + PKT_CYC + 2);
    push_pkt(3, req + 2 * (PKT_CYC + 2));
    step();
    x_value = 12'hABC;
    y_value = 12'hDEF;
    level   = 2'd3;
    wait_until(req + PKT_CYC + 3);
    x_value = 12'h000;
    y_value = 12'hFFF;
    level   = 2'd0;
    wait_until(req + 2 * (PKT_CYC + 2) + 1);
    send_req = 1'b0;
    wait_until(req + 2 * (PKT_CYC + 2) + DONE_OFS + 10);

    // Reset during B2 data bits
    send_pkt(5, 12'h321, 12'h654, 2'd1, req);
    wait_until(req + 2 + 2 * BIT_CYC + 50);
    rst = 1'b1;
    byte_q.delete();
    done_q.delete();
    step();
    @(negedge clk);
    chk("rst_abort_tx", tx, 1);
    chk("rst_abort_busy", busy, 0);
    step();
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    chk("post_rst_idle", idle_ok, 1);
    send_pkt(4, 12'h5A3, 12'h0C6, 2'd2, req);

    for (int t = 0; t < 2000 && (byte_q.size() != 0 || done_q.size() != 0); t++) step();
    repeat (20) step();
    chk("drain_bytes", byte_q.size(), 0);
    chk("drain_done", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
